mmv_to_ps_burst_enc: RTL

MMV_TO_PS_BURST_ENC -- requirements
Module: mmv_to_ps_burst_enc

---
 rtl/mmv_to_ps_burst_enc_pkg.sv | 26 ++
 rtl/mmv_to_ps_burst_enc_buffer.sv | 51 +++++
 rtl/mmv_to_ps_burst_enc.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmv_to_ps_burst_enc_pkg.sv
// Shared definitions for the memory-mapped to packet-stream burst encoder:
// header bit positions, request/response pack-type values and FSM states.
package mmv_ps_pkg;

    // Header beat layout
    localparam int PACK_TYPE_BIT = 0;
    localparam int WREQ_TYPE_BIT = 1;
    localparam int RREQ_TYPE_BIT = 2;
    localparam int BCNT_LSB      = 3;

    // Value of the pack-type bit in the first beat of a packet
    localparam logic PACK_TYPE_REQ = 1'b0;
    localparam logic PACK_TYPE_RES = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_ADDR,
        ST_SEND_WR_DATA
    } enc_state_t;

    // Number of stream beats needed to carry a field of width a
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/mmv_to_ps_burst_enc_buffer.sv
// Two-register output buffer. Both o_val/o_dat and i_rdy come straight from
// flops, so there is no combinational path from o_rdy to the output side or
// back to the input side. Full throughput when o_rdy stays high.
module ps_twinreg_buffer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_val,
    output logic             i_rdy,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_val,
    input  logic             o_rdy
);

    logic             r_main_val;
    logic             r_skid_val;
    logic [WIDTH-1:0] r_main_dat;
    logic [WIDTH-1:0] r_skid_dat;
    logic             w_main_free;

    assign w_main_free = o_rdy | ~r_main_val;
    assign i_rdy       = ~r_skid_val;
    assign o_val       = r_main_val;
    assign o_dat       = r_main_dat;

    // Occupancy: main refills from skid first, otherwise from the input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_val <= 1'b0;
            r_skid_val <= 1'b0;
        end else if (w_main_free) begin
            r_main_val <= r_skid_val | i_val;
            r_skid_val <= 1'b0;
        end else if (i_val & ~r_skid_val) begin
            r_skid_val <= 1'b1;
        end
    end

    // Payload registers follow the occupancy decisions; no reset needed
    always_ff @(posedge clk) begin
        if (w_main_free) begin
            r_main_dat <= r_skid_val ? r_skid_dat : i_dat;
        end
        if (~w_main_free & i_val & ~r_skid_val) begin
            r_skid_dat <= i_dat;
        end
    end

endmodule

// File: rtl/mmv_to_ps_burst_enc.sv
// Memory-mapped to packet-stream burst encoder. Turns s_* write/read bursts
// into request packets (header, address beats LSB-first, write data) and
// forwards the payload of inbound response packets to s_rdat/s_rval.
// Optional read-response timeout: define MMV_TO_PS_BURST_ENC_RD_TIMEOUT_EN.
module mmv_to_ps_burst_enc
    import mmv_ps_pkg::*;
#(
    parameter int DWIDTH         = 8,
    parameter int AWIDTH         = 16,
    parameter int BWIDTH         = 4,
    parameter int RD_OUTSTANDING = 2,
    parameter int TIMEOUT        = 1024
) (
    input  logic              rst,
    input  logic              clk,
    input  logic [AWIDTH-1:0] s_addr,
    input  logic [BWIDTH-1:0] s_bcnt,
    input  logic              s_wreq,
    input  logic [DWIDTH-1:0] s_wdat,
    input  logic              s_rreq,
    output logic [DWIDTH-1:0] s_rdat,
    output logic              s_rval,
    output logic              s_rerr,
    output logic              s_busy,
    input  logic [DWIDTH-1:0] i_dat,
    input  logic              i_val,
    input  logic              i_eop,
    output logic              i_rdy,
    output logic [DWIDTH-1:0] o_dat,
    output logic              o_val,
    output logic              o_eop,
    input  logic              o_rdy
);

    localparam int ABEATS = ceil_div(AWIDTH, DWIDTH);
    localparam int AIW    = (ABEATS > 1) ? $clog2(ABEATS) : 1;
    localparam int OCW    = $clog2(RD_OUTSTANDING + 1);

    enc_state_t                 r_state;
    logic [AWIDTH-1:0]          r_addr;
    logic [BWIDTH-1:0]          r_bcnt;
    logic                       r_is_wr;
    logic [AIW-1:0]             r_abeat;
    logic [BWIDTH-1:0]          r_dbeat;
    logic [OCW-1:0]             r_rd_out;
    logic                       r_sop;
    logic                       r_in_resp;

    logic [DWIDTH-1:0]          w_hdr;
    logic [ABEATS*DWIDTH-1:0]   w_addr_pad;
    logic                       w_last_abeat;
    logic                       w_last_dbeat;
    logic                       w_rd_ok;
    logic                       w_push;
    logic                       w_push_eop;
    logic [DWIDTH-1:0]          w_push_dat;
    logic                       w_buf_rdy;
    logic                       w_acc;
    logic                       w_rd_acc;
    logic                       w_rsp_beat;
    logic                       w_dec;
    logic                       w_tmo_hit;
    logic [DWIDTH:0]            w_buf_out;

    // Header beat built from the live request inputs
    always_comb begin
        w_hdr                          = '0;
        w_hdr[PACK_TYPE_BIT]           = PACK_TYPE_REQ;
        w_hdr[WREQ_TYPE_BIT]           = s_wreq;
        w_hdr[RREQ_TYPE_BIT]           = s_rreq;
        w_hdr[BCNT_LSB +: BWIDTH]      = s_bcnt;
    end

    // Latched address zero-padded to a whole number of beats
    always_comb begin
        w_addr_pad               = '0;
        w_addr_pad[AWIDTH-1:0]   = r_addr;
    end

    assign w_last_abeat = (r_abeat == AIW'(ABEATS - 1));
    assign w_last_dbeat = (r_dbeat == r_bcnt);
    assign w_rd_ok      = (r_rd_out != OCW'(RD_OUTSTANDING));
    assign w_acc        = w_push & w_buf_rdy;
    assign w_rd_acc     = (r_state == ST_SEND_ADDR) & w_acc & w_last_abeat & ~r_is_wr;

    // Beat selection and busy handshake for the current FSM state
    always_comb begin
        w_push     = 1'b0;
        w_push_dat = '0;
        w_push_eop = 1'b0;
        s_busy     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_push_dat = w_hdr;
                w_push     = s_wreq | (s_rreq & w_rd_ok);
            end
            ST_SEND_ADDR: begin
                w_push     = 1'b1;
                w_push_dat = w_addr_pad[int'(r_abeat)*DWIDTH +: DWIDTH];
                w_push_eop = w_last_abeat & ~r_is_wr;
                if (w_last_abeat & ~r_is_wr & w_buf_rdy) begin
                    s_busy = 1'b0;
                end
            end
            ST_SEND_WR_DATA: begin
                s_busy     = ~w_buf_rdy;
                w_push     = s_wreq;
                w_push_dat = s_wdat;
                w_push_eop = w_last_dbeat;
            end
            default: ;
        endcase
    end

    // Request FSM: header, address beats, then write data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_is_wr <= 1'b0;
            r_abeat <= '0;
            r_dbeat <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        r_state <= ST_SEND_ADDR;
                        r_is_wr <= s_wreq;
                        r_abeat <= '0;
                    end
                end
                ST_SEND_ADDR: begin
                    if (w_acc) begin
                        if (w_last_abeat) begin
                            r_dbeat <= '0;
                            r_state <= r_is_wr ? ST_SEND_WR_DATA : ST_IDLE;
                        end else begin
                            r_abeat <= r_abeat + AIW'(1);
                        end
                    end
                end
                ST_SEND_WR_DATA: begin
                    if (w_acc) begin
                        if (w_last_dbeat) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_dbeat <= r_dbeat + BWIDTH'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Capture address and burst count when the header is accepted
    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && w_acc) begin
            r_addr <= s_addr;
            r_bcnt <= s_bcnt;
        end
    end

    ps_twinreg_buffer #(
        .WIDTH (DWIDTH + 1)
    ) u_obuf (
        .clk   (clk),
        .rst   (rst),
        .i_dat ({w_push_eop, w_push_dat}),
        .i_val (w_push),
        .i_rdy (w_buf_rdy),
        .o_dat (w_buf_out),
        .o_val (o_val),
        .o_rdy (o_rdy)
    );

    assign o_eop = w_buf_out[DWIDTH];
    assign o_dat = w_buf_out[DWIDTH-1:0];

    // Inbound side: always ready, classify packets by their first beat
    assign i_rdy      = 1'b1;
    assign s_rdat     = i_dat;
    assign s_rval     = i_val & ~r_sop & r_in_resp;
    assign w_rsp_beat = i_val & (r_sop ? (i_dat[PACK_TYPE_BIT] == PACK_TYPE_RES) : r_in_resp);
    assign w_dec      = w_rsp_beat & i_eop & (r_rd_out != '0);

    // SOP flag and response-packet flag for the inbound stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sop     <= 1'b1;
            r_in_resp <= 1'b0;
        end else if (i_val) begin
            r_sop <= i_eop;
            if (r_sop) begin
                r_in_resp <= (i_dat[PACK_TYPE_BIT] == PACK_TYPE_RES);
            end
        end
    end

    // Outstanding reads: up on read issue, down on response eop, cleared on timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_out <= '0;
        end else if (w_tmo_hit) begin
            r_rd_out <= w_rd_acc ? OCW'(1) : '0;
        end else if (w_rd_acc & ~w_dec) begin
            r_rd_out <= r_rd_out + OCW'(1);
        end else if (~w_rd_acc & w_dec) begin
            r_rd_out <= r_rd_out - OCW'(1);
        end
    end

`ifdef MMV_TO_PS_BURST_ENC_RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tmo;
    logic          r_rerr;

    assign w_tmo_hit = (r_rd_out != '0) && (r_tmo == TW'(TIMEOUT - 1));
    assign s_rerr    = r_rerr;

    // Response watchdog: idles at 0, restarts on every response beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo  <= '0;
            r_rerr <= 1'b0;
        end else begin
            r_rerr <= w_tmo_hit;
            if ((r_rd_out == '0) || w_rsp_beat || w_tmo_hit) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_tmo_hit        = 1'b0;
    assign s_rerr           = 1'b0;
`endif

endmodule
